// File: rtl/loop_addr_gen_pkg.sv
// ============================================================================
// Module   : loop_addr_gen_pkg
// Brief    : Shared FSM encoding and sizing constants for loop_addr_gen.
// Revision : 1.0
// ============================================================================
`default_nettype none

package loop_addr_gen_pkg;

    localparam int c_num_lvl = 3;
    localparam int c_stall_w = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loop_addr_gen_level.sv
// ============================================================================
// Module   : loop_level
// Brief    : One loop level: index, latched bound/stride and running address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module loop_level #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [DIM_W-1:0]  i_max,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [ADDR_W-1:0] i_up_new,
    output logic              o_wrap,
    output logic [ADDR_W-1:0] o_acc,
    output logic [ADDR_W-1:0] o_new
);

    logic [DIM_W-1:0]  r_idx;
    logic [DIM_W-1:0]  r_max;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_acc;

    // On wrap this level restarts from whatever the level above moves to.
    assign o_wrap = (r_idx == r_max);
    assign o_new  = o_wrap ? i_up_new : (r_acc + r_stride);
    assign o_acc  = r_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx    <= '0;
            r_max    <= '0;
            r_stride <= '0;
            r_acc    <= '0;
        end else if (i_clr) begin
            r_idx    <= '0;
            r_max    <= i_max;
            r_stride <= i_stride;
            r_acc    <= i_base;
        end else if (i_inc) begin
            r_idx <= o_wrap ? '0 : (r_idx + DIM_W'(1));
            r_acc <= o_new;
        end
    end

endmodule

`default_nettype wire

// File: rtl/loop_addr_gen.sv
// ============================================================================
// Module   : loop_addr_gen
// Brief    : Three-level nested-loop address generator on a valid/ready stream.
//            Optional stall counter output enabled by LOOP_ADDR_GEN_STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module loop_addr_gen
    import loop_addr_gen_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_cfg_base,
    input  logic [DIM_W-1:0]     i_cfg_max0,
    input  logic [DIM_W-1:0]     i_cfg_max1,
    input  logic [DIM_W-1:0]     i_cfg_max2,
    input  logic [ADDR_W-1:0]    i_cfg_stride0,
    input  logic [ADDR_W-1:0]    i_cfg_stride1,
    input  logic [ADDR_W-1:0]    i_cfg_stride2,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_addr_vld,
    input  logic                 i_addr_rdy,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 o_addr_last,
    output logic [c_num_lvl-1:0] o_lvl_inc,
    output logic [c_num_lvl-1:0] o_lvl_ovf
`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
    ,
    output logic [c_stall_w-1:0] o_stall_cnt
`endif
);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_vld;

    logic                  w_start_acc;
    logic                  w_fire;
    logic [c_num_lvl-1:0]  w_wrap;
    logic [c_num_lvl-1:0]  w_inc;
    logic [DIM_W-1:0]      w_max    [c_num_lvl];
    logic [ADDR_W-1:0]     w_stride [c_num_lvl];
    logic [ADDR_W-1:0]     w_acc    [c_num_lvl];
    logic [ADDR_W-1:0]     w_new    [c_num_lvl];
    logic [ADDR_W-1:0]     w_up_new [c_num_lvl];

    assign w_max[0]    = i_cfg_max0;
    assign w_max[1]    = i_cfg_max1;
    assign w_max[2]    = i_cfg_max2;
    assign w_stride[0] = i_cfg_stride0;
    assign w_stride[1] = i_cfg_stride1;
    assign w_stride[2] = i_cfg_stride2;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_fire      = r_vld && i_addr_rdy;

    // A level steps only when every level below it wraps on this beat.
    assign w_inc[0] = w_fire;
    assign w_inc[1] = w_inc[0] & w_wrap[0];
    assign w_inc[2] = w_inc[1] & w_wrap[1];

    assign o_lvl_inc   = w_inc;
    assign o_lvl_ovf   = w_inc & w_wrap;
    assign o_addr_last = r_vld & (&w_wrap);
    assign o_addr      = w_acc[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_addr_vld  = r_vld;

    generate
        for (genvar k = 0; k < c_num_lvl; k++) begin : g_lvl
            if (k == c_num_lvl - 1) begin : g_outer
                assign w_up_new[k] = '0;
            end else begin : g_inner
                assign w_up_new[k] = w_new[k+1];
            end

            loop_level #(
                .ADDR_W (ADDR_W),
                .DIM_W  (DIM_W)
            ) u_level (
                .clk      (clk),
                .rstn     (rstn),
                .i_clr    (w_start_acc),
                .i_inc    (w_inc[k]),
                .i_base   (i_cfg_base),
                .i_max    (w_max[k]),
                .i_stride (w_stride[k]),
                .i_up_new (w_up_new[k]),
                .o_wrap   (w_wrap[k]),
                .o_acc    (w_acc[k]),
                .o_new    (w_new[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_vld   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_fire && o_addr_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_vld   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
    logic [c_stall_w-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (r_vld && !i_addr_rdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_loop_addr_gen.sv
// ============================================================================
// Module   : tb_loop_addr_gen
// Brief    : Self-checking bench for loop_addr_gen: vector table, corner
//            sequences and random sweeps against a nested-loop address model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_loop_addr_gen;

    typedef struct {
        logic [15:0] base;
        logic [7:0]  m0, m1, m2;
        logic [15:0] s0, s1, s2;
        int          rdy_mode;
        int          exp_beats;
        logic [15:0] exp_last_addr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        last;
        logic [2:0]  inc;
        logic [2:0]  ovf;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start;
    logic [15:0] i_cfg_base;
    logic [7:0]  i_cfg_max0, i_cfg_max1, i_cfg_max2;
    logic [15:0] i_cfg_stride0, i_cfg_stride1, i_cfg_stride2;
    logic        o_busy, o_done, o_addr_vld, i_addr_rdy, o_addr_last;
    logic [15:0] o_addr;
    logic [2:0]  o_lvl_inc, o_lvl_ovf;
`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    int    n_chk = 0;
    int    n_err = 0;
    beat_t q[$];
    vec_t  vecs[6];

    always #5 clk = ~clk;

    loop_addr_gen #(.ADDR_W(16), .DIM_W(8)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_start       (i_start),
        .i_cfg_base    (i_cfg_base),
        .i_cfg_max0    (i_cfg_max0),
        .i_cfg_max1    (i_cfg_max1),
        .i_cfg_max2    (i_cfg_max2),
        .i_cfg_stride0 (i_cfg_stride0),
        .i_cfg_stride1 (i_cfg_stride1),
        .i_cfg_stride2 (i_cfg_stride2),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_addr_vld    (o_addr_vld),
        .i_addr_rdy    (i_addr_rdy),
        .o_addr        (o_addr),
        .o_addr_last   (o_addr_last),
        .o_lvl_inc     (o_lvl_inc),
        .o_lvl_ovf     (o_lvl_ovf)
`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
        ,
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_done"}, o_done, 0);
        chk({nm, "_vld"},  o_addr_vld, 0);
        chk({nm, "_addr"}, o_addr, 0);
        chk({nm, "_last"}, o_addr_last, 0);
        chk({nm, "_inc"},  o_lvl_inc, 0);
        chk({nm, "_ovf"},  o_lvl_ovf, 0);
    endtask

    // Expected beats straight from the loop nest: addr = base + sum(i_k * stride_k).
    task automatic build_model(input vec_t v);
        beat_t b;
        bit    e0, e1, e2;
        q.delete();
        for (int i2 = 0; i2 <= int'(v.m2); i2++) begin
            for (int i1 = 0; i1 <= int'(v.m1); i1++) begin
                for (int i0 = 0; i0 <= int'(v.m0); i0++) begin
                    e0 = (i0 == int'(v.m0));
                    e1 = (i1 == int'(v.m1));
                    e2 = (i2 == int'(v.m2));
                    b.addr = 16'(int'(v.base) + i0 * int'(v.s0) + i1 * int'(v.s1) + i2 * int'(v.s2));
                    b.last = e0 & e1 & e2;
                    b.inc  = {e0 & e1, e0, 1'b1};
                    b.ovf  = {e0 & e1 & e2, e0 & e1, e0};
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic apply_cfg(input vec_t v);
        i_cfg_base    = v.base;
        i_cfg_max0    = v.m0;
        i_cfg_max1    = v.m1;
        i_cfg_max2    = v.m2;
        i_cfg_stride0 = v.s0;
        i_cfg_stride1 = v.s1;
        i_cfg_stride2 = v.s2;
    endtask

    task automatic run_sweep(input vec_t v, input bit inject);
        int          cyc = 0;
        int          fired = 0;
        int          stalls = 0;
        logic [15:0] last_addr = 16'h0;
        bit          fire;
        build_model(v);
        @(posedge clk); #1;
        apply_cfg(v);
        i_start    = 1'b1;
        i_addr_rdy = 1'b0;
        #1;
        chk("idle_vld", o_addr_vld, 0);
        chk("idle_busy", o_busy, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        while (1) begin
            // Mid-sweep start with a different config, then start during DONE.
            if (inject && cyc == 3) begin
                i_start       = 1'b1;
                i_cfg_base    = 16'h5555;
                i_cfg_max0    = 8'd7;
                i_cfg_stride0 = 16'h0333;
            end else begin
                i_start = inject && (q.size() == 0);
            end
            case (v.rdy_mode)
                0:       i_addr_rdy = 1'b1;
                1:       i_addr_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: i_addr_rdy = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (!o_addr_vld) break;
            chk("busy", o_busy, 1);
            chk("done_early", o_done, 0);
            if (q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                chk("addr", o_addr, q[0].addr);
                chk("last", o_addr_last, q[0].last);
                chk("lvl_inc", o_lvl_inc, i_addr_rdy ? q[0].inc : 3'b000);
                chk("lvl_ovf", o_lvl_ovf, i_addr_rdy ? q[0].ovf : 3'b000);
            end
            fire = i_addr_rdy;
            if (fire) begin
                fired++;
                last_addr = o_addr;
                if (q.size() != 0) void'(q.pop_front());
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 4000) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        chk("done_pulse", o_done, 1);
        chk("busy_in_done", o_busy, 0);
        chk("beats", fired, v.exp_beats);
        chk("last_addr", last_addr, v.exp_last_addr);
        chk("model_drained", q.size(), 0);
`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
        chk("stall_cnt", o_stall_cnt, stalls);
`endif
        @(posedge clk); #1;
        i_start = 1'b0;
        #1;
        chk("after_done_vld", o_addr_vld, 0);
        chk("after_done_busy", o_busy, 0);
        chk("after_done_done", o_done, 0);
`ifdef LOOP_ADDR_GEN_STALL_CNT_EN
        chk("stall_cnt_hold", o_stall_cnt, stalls);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{16'h0100, 8'd2, 8'd1, 8'd0, 16'h0001, 16'h0010, 16'h0000, 0, 6,  16'h0112};
        vecs[1] = '{16'h0100, 8'd2, 8'd1, 8'd0, 16'h0001, 16'h0010, 16'h0000, 1, 6,  16'h0112};
        vecs[2] = '{16'hABCD, 8'd0, 8'd0, 8'd0, 16'h0001, 16'h0001, 16'h0001, 0, 1,  16'hABCD};
        vecs[3] = '{16'hFFFE, 8'd3, 8'd0, 8'd0, 16'h0001, 16'h0000, 16'h0000, 0, 4,  16'h0001};
        vecs[4] = '{16'h0200, 8'd1, 8'd1, 8'd1, 16'h0004, 16'h0020, 16'h0100, 2, 8,  16'h0324};
        vecs[5] = '{16'h1000, 8'd3, 8'd2, 8'd1, 16'h0002, 16'h0040, 16'h0800, 1, 24, 16'h1886};

        rstn       = 1'b0;
        i_start    = 1'b0;
        i_addr_rdy = 1'b0;
        apply_cfg(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) run_sweep(vecs[i], 1'b0);

        run_sweep(vecs[0], 1'b1);

        // Reset while the third beat is on the bus.
        @(posedge clk); #1;
        apply_cfg(vecs[0]);
        i_start    = 1'b1;
        i_addr_rdy = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_addr", o_addr, 16'h0102);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("mid_rst");
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_done", o_done, 0);
            chk("post_rst_vld", o_addr_vld, 0);
            @(posedge clk); #1;
        end
        run_sweep(vecs[0], 1'b0);

        for (int n = 0; n < 20; n++) begin
            rv.base     = 16'($urandom);
            rv.m0       = 8'($urandom_range(0, 3));
            rv.m1       = 8'($urandom_range(0, 3));
            rv.m2       = 8'($urandom_range(0, 2));
            rv.s0       = 16'($urandom);
            rv.s1       = 16'($urandom);
            rv.s2       = 16'($urandom);
            rv.rdy_mode = 2;
            rv.exp_beats = (int'(rv.m0) + 1) * (int'(rv.m1) + 1) * (int'(rv.m2) + 1);
            rv.exp_last_addr = 16'(int'(rv.base) + int'(rv.m0) * int'(rv.s0)
                                   + int'(rv.m1) * int'(rv.s1) + int'(rv.m2) * int'(rv.s2));
            run_sweep(rv, n[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
